// File: rtl/qpa_pkg.sv
// Constants and helpers shared by the quad-port arbiter and its response pipes.
package qpa_pkg;

    localparam int NUM_PORTS = 4;

    localparam logic [1:0] PORT_A = 2'd0;
    localparam logic [1:0] PORT_B = 2'd1;
    localparam logic [1:0] PORT_C = 2'd2;
    localparam logic [1:0] PORT_D = 2'd3;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/qpa_rsp_pipe.sv
// Purpose: delays a port's {read-valid, requester id} tag to line up with BRAM DOUT.
// Latency: DEPTH cycles, fixed.
// Backpressure: none; the tag advances every cycle and is cleared by reset.
module qpa_rsp_pipe #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 3
) (
    input  logic            core_clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [ID_W-1:0] in_id,
    output logic            out_vld,
    output logic [ID_W-1:0] out_id
);

    logic [DEPTH-1:0]           vld_sr;
    logic [DEPTH-1:0][ID_W-1:0] id_sr;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            vld_sr <= '0;
            id_sr  <= '0;
        end else begin
            vld_sr[0] <= in_vld;
            id_sr[0]  <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                id_sr[i]  <= id_sr[i-1];
            end
        end
    end

    assign out_vld = vld_sr[DEPTH-1];
    assign out_id  = id_sr[DEPTH-1];

endmodule

// File: rtl/quad_port_arbiter.sv
// Purpose: round-robin grant of up to four requests per cycle onto BRAM ports A-D, with read return routing.
// Latency: port drive 1 cycle after handshake; read data READ_LATENCY+2 cycles after handshake.
// Backpressure: REQ_READY low for unselected, hazarded, disabled or in-reset requesters; responses cannot stall.
module quad_port_arbiter
    import qpa_pkg::*;
#(
    parameter int NUM_REQ      = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                          CLK_1X,
    input  logic                          RST,
    input  logic                          ENABLE,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ-1:0]            REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DIN,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [NUM_REQ*DATA_WIDTH-1:0] RSP_DOUT,
    output logic [ADDR_WIDTH-1:0]         BRAM_PORTA_ADDR,
    output logic [DATA_WIDTH-1:0]         BRAM_PORTA_DIN,
    output logic                          BRAM_PORTA_EN,
    output logic                          BRAM_PORTA_WE,
    input  logic [DATA_WIDTH-1:0]         BRAM_PORTA_DOUT,
    output logic [ADDR_WIDTH-1:0]         BRAM_PORTB_ADDR,
    output logic [DATA_WIDTH-1:0]         BRAM_PORTB_DIN,
    output logic                          BRAM_PORTB_EN,
    output logic                          BRAM_PORTB_WE,
    input  logic [DATA_WIDTH-1:0]         BRAM_PORTB_DOUT,
    output logic [ADDR_WIDTH-1:0]         BRAM_PORTC_ADDR,
    output logic [DATA_WIDTH-1:0]         BRAM_PORTC_DIN,
    output logic                          BRAM_PORTC_EN,
    output logic                          BRAM_PORTC_WE,
    input  logic [DATA_WIDTH-1:0]         BRAM_PORTC_DOUT,
    output logic [ADDR_WIDTH-1:0]         BRAM_PORTD_ADDR,
    output logic [DATA_WIDTH-1:0]         BRAM_PORTD_DIN,
    output logic                          BRAM_PORTD_EN,
    output logic                          BRAM_PORTD_WE,
    input  logic [DATA_WIDTH-1:0]         BRAM_PORTD_DOUT
);

    localparam int IDW = id_width(NUM_REQ);

    logic [IDW-1:0]                       rr_ptr;
    logic [IDW-1:0]                       rr_nxt;
    logic [NUM_REQ-1:0]                   grant;
    logic [NUM_PORTS-1:0]                 sel_vld;
    logic [NUM_PORTS-1:0]                 sel_we;
    logic [NUM_PORTS-1:0][IDW-1:0]        sel_id;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] sel_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] sel_din;

    // Two passes over fixed indices realise the rotated scan rr_ptr..NUM_REQ-1, 0..rr_ptr-1
    // while keeping every vector select constant.
    always_comb begin
        logic [2:0]            n;
        logic                  hazard;
        logic                  in_pass;
        logic [ADDR_WIDTH-1:0] cand_addr;

        grant     = '0;
        sel_vld   = '0;
        sel_we    = '0;
        sel_id    = '0;
        sel_addr  = '0;
        sel_din   = '0;
        rr_nxt    = rr_ptr;
        n         = '0;
        hazard    = 1'b0;
        in_pass   = 1'b0;
        cand_addr = '0;
        if (!RST && ENABLE) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    in_pass   = (pass == 0) ? (j >= int'(rr_ptr)) : (j < int'(rr_ptr));
                    cand_addr = REQ_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH];
                    hazard    = 1'b0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (sel_vld[p] && sel_addr[p] == cand_addr && (REQ_WE[j] || sel_we[p]))
                            hazard = 1'b1;
                    end
                    if (in_pass && REQ_VALID[j] && n < 3'(NUM_PORTS) && !hazard) begin
                        grant[j]          = 1'b1;
                        sel_vld[n[1:0]]   = 1'b1;
                        sel_we[n[1:0]]    = REQ_WE[j];
                        sel_id[n[1:0]]    = IDW'(j);
                        sel_addr[n[1:0]]  = cand_addr;
                        sel_din[n[1:0]]   = REQ_DIN[j*DATA_WIDTH +: DATA_WIDTH];
                        rr_nxt            = (j == NUM_REQ - 1) ? '0 : IDW'(j + 1);
                        n                 = n + 3'd1;
                    end
                end
            end
        end
    end

    assign REQ_READY = grant;

    logic [NUM_PORTS-1:0]                 port_en;
    logic [NUM_PORTS-1:0]                 port_we;
    logic [NUM_PORTS-1:0][IDW-1:0]        port_id;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_din;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_dout;

    always_ff @(posedge CLK_1X) begin
        if (RST) begin
            rr_ptr    <= '0;
            port_en   <= '0;
            port_we   <= '0;
            port_id   <= '0;
            port_addr <= '0;
            port_din  <= '0;
        end else begin
            rr_ptr    <= rr_nxt;
            port_en   <= sel_vld;
            port_we   <= sel_we;
            port_id   <= sel_id;
            port_addr <= sel_addr;
            port_din  <= sel_din;
        end
    end

    assign BRAM_PORTA_EN   = port_en[PORT_A];
    assign BRAM_PORTA_WE   = port_we[PORT_A];
    assign BRAM_PORTA_ADDR = port_addr[PORT_A];
    assign BRAM_PORTA_DIN  = port_din[PORT_A];
    assign BRAM_PORTB_EN   = port_en[PORT_B];
    assign BRAM_PORTB_WE   = port_we[PORT_B];
    assign BRAM_PORTB_ADDR = port_addr[PORT_B];
    assign BRAM_PORTB_DIN  = port_din[PORT_B];
    assign BRAM_PORTC_EN   = port_en[PORT_C];
    assign BRAM_PORTC_WE   = port_we[PORT_C];
    assign BRAM_PORTC_ADDR = port_addr[PORT_C];
    assign BRAM_PORTC_DIN  = port_din[PORT_C];
    assign BRAM_PORTD_EN   = port_en[PORT_D];
    assign BRAM_PORTD_WE   = port_we[PORT_D];
    assign BRAM_PORTD_ADDR = port_addr[PORT_D];
    assign BRAM_PORTD_DIN  = port_din[PORT_D];

    assign port_dout[PORT_A] = BRAM_PORTA_DOUT;
    assign port_dout[PORT_B] = BRAM_PORTB_DOUT;
    assign port_dout[PORT_C] = BRAM_PORTC_DOUT;
    assign port_dout[PORT_D] = BRAM_PORTD_DOUT;

    logic [NUM_PORTS-1:0]          pipe_vld;
    logic [NUM_PORTS-1:0][IDW-1:0] pipe_id;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pipe
        qpa_rsp_pipe #(
            .DEPTH (READ_LATENCY),
            .ID_W  (IDW)
        ) u_rsp_pipe (
            .core_clk (CLK_1X),
            .rst      (RST),
            .in_vld   (port_en[p] & ~port_we[p]),
            .in_id    (port_id[p]),
            .out_vld  (pipe_vld[p]),
            .out_id   (pipe_id[p])
        );
    end

    logic [NUM_REQ-1:0]            rsp_vld;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_dout;

    // A requester issues at most once per cycle, so at most one port targets each slot here.
    always_ff @(posedge CLK_1X) begin
        if (RST) begin
            rsp_vld  <= '0;
            rsp_dout <= '0;
        end else begin
            rsp_vld <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (pipe_vld[p] && pipe_id[p] == IDW'(r)) begin
                        rsp_vld[r]                          <= 1'b1;
                        rsp_dout[r*DATA_WIDTH +: DATA_WIDTH] <= port_dout[p];
                    end
                end
            end
        end
    end

    assign RSP_VALID = rsp_vld;
    assign RSP_DOUT  = rsp_dout;

endmodule

// File: doc/quad_port_arbiter.md
Name: quad_port_arbiter

Overview:
- Shares the four logical ports (A–D) of the quad-port BRAM wrapper among NUM_REQ requesters, such as solver processing elements.
- Each cycle, grants up to four requests in round-robin order and drives one port per grant.
- Tracks in-flight reads and routes each returned word back to the requester that issued it.
- Sits between the requester fabric and the quad-port BRAM wrapper, in the CLK_1X domain.

Parameters:
- NUM_REQ, 8, number of requesters (range 4–16).
- ADDR_WIDTH, 11, BRAM word address width.
- DATA_WIDTH, 32, data word width.
- READ_LATENCY, 2, cycles from port EN/ADDR driven to valid DOUT at the wrapper's logical port.

Ports:
- CLK_1X  in  1  single clock.
- RST  in  1  synchronous reset, active-high.
- ENABLE  in  1  grants allowed when high.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  per-requester grant (handshake completes when VALID&READY).
- REQ_WE  in  NUM_REQ  1 = write, 0 = read.
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_DIN  in  NUM_REQ*DATA_WIDTH  packed write data.
- RSP_VALID  out  NUM_REQ  read data valid, one cycle pulse.
- RSP_DOUT  out  NUM_REQ*DATA_WIDTH  packed read data.
- BRAM_PORT{A,B,C,D}_ADDR  out  ADDR_WIDTH  each port address.
- BRAM_PORT{A,B,C,D}_DIN  out  DATA_WIDTH  each port write data.
- BRAM_PORT{A,B,C,D}_EN  out  1  each port enable.
- BRAM_PORT{A,B,C,D}_WE  out  1  each port write enable.
- BRAM_PORT{A,B,C,D}_DOUT  in  DATA_WIDTH  each port read data.

Behaviour:
- Reset (RST high at a CLK_1X edge): all BRAM_PORT* outputs 0; RSP_VALID 0; RSP_DOUT 0; rr_ptr = 0; all in-flight read tracking cleared.
  - Reads in flight when reset is asserted are dropped; no RSP_VALID is produced for them.
  - REQ_READY is 0 while RST is high.
- Grant selection is combinational within cycle t:
  - Scan requesters in order rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - Select up to 4 with REQ_VALID=1, assigned to ports A, B, C, D in scan order.
  - REQ_READY[i]=1 only for selected requesters. REQ_READY may depend on REQ_VALID; requesters must not make VALID depend on READY.
- Address hazard: a candidate is skipped (left pending, READY=0) if its address equals that of an already-selected request in the same cycle and either of the two is a write. Two reads of the same address are both granted.
- ENABLE=0: no grants, REQ_READY all 0. In-flight reads still complete and return.
- Pointer update at the edge ending cycle t:
  - If at least one grant: rr_ptr = (index of last granted requester + 1) mod NUM_REQ.
  - If no grant: rr_ptr is unchanged.
- Port drive: registered. A grant in cycle t drives BRAM_PORTx_EN=1 with ADDR/DIN/WE in cycle t+1. Ports without a grant drive EN=0, WE=0, and ADDR/DIN = 0.
- Read return:
  - Each port carries a READ_LATENCY-deep shift register of {valid, requester_id}.
  - At cycle t+1+READ_LATENCY, BRAM_PORTx_DOUT is captured into RSP_DOUT[id] and RSP_VALID[id] pulses in cycle t+2+READ_LATENCY.
  - Total read latency is READ_LATENCY+2 cycles from handshake; this is fixed.
- Writes produce no response.
- Ordering: responses per requester are in issue order (fixed latency). A requester may issue every cycle.
- Each requester issues at most one request per cycle, so at most one response per requester per cycle; no return collisions occur.
- RSP_DOUT[i] holds its last value when RSP_VALID[i]=0.

Decomposition:
- Shared package (qpa_pkg): NUM_PORTS=4; port index encodings PORT_A..PORT_D=0..3; requester ID width = $clog2(NUM_REQ).
- Sub-module qpa_rsp_pipe, instantiated 4×: valid/ID delay line of depth READ_LATENCY with synchronous reset; outputs the {valid, id} pair aligned with DOUT.
- Grant scan and hazard check live in the top module as one combinational block.

Test Plan:
- Reset then all 8 requesters issue reads (addresses 0x10+i) with rr_ptr=0 -> cycle 0 grants 0–3 on A–D; cycle 1 grants 4–7; RSP_VALID[0..3] at cycle 4 and RSP_VALID[4..7] at cycle 5 (READ_LATENCY=2), data matching preloaded memory.
- Requester 2 writes 0xDEADBEEF to 0x05 while requester 3 reads 0x05 in the same cycle -> only requester 2 is granted; requester 3 is granted next cycle and returns 0xDEADBEEF.
- Requesters 1 and 6 both read 0x7FF in the same cycle -> both granted; both RSP_VALID pulse together with identical data.
- Only requester 5 valid for 3 cycles -> granted every cycle on port A; rr_ptr=6 after each grant; three RSP_VALID[5] pulses on consecutive cycles.
- Read granted at cycle t, RST asserted at t+2 -> no RSP_VALID[*] at t+4; all BRAM_PORT*_EN=0 at t+3.
- ENABLE=0 with all valid for 5 cycles -> REQ_READY=0 throughout and rr_ptr unchanged; earlier in-flight reads still return.
